aes_decipher: RTL and testbench

Iterative AES inverse cipher datapath: one round per clock, AES-128 (10 rounds) or AES-256 (14 rounds). It pairs with `AES_encipher` and sits beside it under the AES top level. It shares the same external key-expansion memory: the block requests round keys by index on `round`, in descending order Nr..0. Result is held on `new_block`, with a one-cycle `ready` pulse.

---
 rtl/aes_decipher_pkg.sv | 61 ++++++
 rtl/aes_decipher_inv_mix_column.sv | 26 ++
 rtl/aes_decipher.sv | 118 +++++++++++
 tb/tb_aes_decipher.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_decipher_pkg.sv
// Shared AES constants: forward and inverse S-boxes, round counts and GF(2^8) helpers.
package aes_decipher_pkg;

    localparam logic [3:0] AES128_ROUNDS = 4'd10;
    localparam logic [3:0] AES256_ROUNDS = 4'd14;

    // Element 0 sits in the most significant byte, so TABLE[x] is the lookup for x.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant, enough for the {09,0b,0d,0e} coefficients.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return (c[0] ? b : '0) ^ (c[1] ? x2 : '0) ^ (c[2] ? x4 : '0) ^ (c[3] ? x8 : '0);
    endfunction

endpackage

// File: rtl/aes_decipher_inv_mix_column.sv
// InvMixColumns on a single 32-bit column; byte [31:24] is row 0.
module aes_inv_mix_column
    import aes_decipher_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        a0 = col_in[31:24];
        a1 = col_in[23:16];
        a2 = col_in[15:8];
        a3 = col_in[7:0];
        col_out[31:24] = gf_mul_const(a0, 4'he) ^ gf_mul_const(a1, 4'hb)
                       ^ gf_mul_const(a2, 4'hd) ^ gf_mul_const(a3, 4'h9);
        col_out[23:16] = gf_mul_const(a0, 4'h9) ^ gf_mul_const(a1, 4'he)
                       ^ gf_mul_const(a2, 4'hb) ^ gf_mul_const(a3, 4'hd);
        col_out[15:8]  = gf_mul_const(a0, 4'hd) ^ gf_mul_const(a1, 4'h9)
                       ^ gf_mul_const(a2, 4'he) ^ gf_mul_const(a3, 4'hb);
        col_out[7:0]   = gf_mul_const(a0, 4'hb) ^ gf_mul_const(a1, 4'hd)
                       ^ gf_mul_const(a2, 4'h9) ^ gf_mul_const(a3, 4'he);
    end

endmodule

// File: rtl/aes_decipher.sv
// Iterative AES-128/256 inverse cipher, one round per clock; round keys fetched by index.
module aes_decipher
    import aes_decipher_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        MAIN,
        FINAL
    } state_t;

    state_t       state, state_next;
    logic [3:0]   round_reg, round_next;
    logic [127:0] block_reg, block_next;
    logic         ready_reg, ready_next;
    logic [127:0] inv_sb;
    logic [127:0] imc_in;
    logic [127:0] imc_out;

    // State byte i lives at [127-8i -: 8]; s[r][c] is byte 4c+r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                res[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            res[127 - 8*i -: 8] = INV_SBOX[s[127 - 8*i -: 8]];
        end
        return res;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    assign inv_sb = inv_sub_bytes(inv_shift_rows(block_reg));
    assign imc_in = add_round_key(inv_sb, round_key);

    for (genvar g = 0; g < 4; g++) begin : g_imc
        aes_inv_mix_column u_imc (
            .col_in  (imc_in[127 - 32*g -: 32]),
            .col_out (imc_out[127 - 32*g -: 32])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            round_reg <= '0;
            block_reg <= '0;
            ready_reg <= 1'b0;
        end else begin
            state     <= state_next;
            round_reg <= round_next;
            block_reg <= block_next;
            ready_reg <= ready_next;
        end
    end

    // keylen only matters at acceptance: the loaded round count carries it from then on.
    always_comb begin
        state_next = state;
        round_next = round_reg;
        block_next = block_reg;
        ready_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (next) begin
                    round_next = keylen ? AES256_ROUNDS : AES128_ROUNDS;
                    state_next = INIT;
                end
            end
            INIT: begin
                block_next = add_round_key(block, round_key);
                round_next = round_reg - 4'd1;
                state_next = MAIN;
            end
            MAIN: begin
                block_next = imc_out;
                round_next = round_reg - 4'd1;
                if (round_reg == 4'd1) begin
                    state_next = FINAL;
                end
            end
            FINAL: begin
                block_next = imc_in;
                ready_next = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign round     = round_reg;
    assign new_block = block_reg;
    assign ready     = ready_reg;

endmodule

// File: tb/tb_aes_decipher.sv
// Scoreboard bench for aes_decipher using FIPS-197 vectors and a behavioural key schedule.
module tb_aes_decipher;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         next = 1'b0;
    logic         keylen = 1'b0;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block = '0;
    logic [127:0] new_block;
    logic         ready;

    always #5 clk = ~clk;

    aes_decipher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    typedef struct {
        logic [127:0] pt;
        int           e0;
        int           nr;
    } exp_t;

    logic [127:0] rk [0:1][0:14];
    logic [7:0]   sbox_t [0:255];
    int           cur_sel = 0;
    exp_t         exp_q [$];
    int           ready_cyc [$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;

    assign round_key = rk[cur_sel][round];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic load_key(input int sel, input logic [255:0] key, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per ready pulse and tracks the round index in flight.
    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (rst_n) begin
            if (ready === 1'b1) begin
                ready_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check128("plaintext", new_block, e.pt);
                    check_int("ready_latency", cyc - e.e0, e.nr + 1);
                end
            end else if (exp_q.size() != 0) begin
                k = cyc - exp_q[0].e0;
                if (k >= 0 && k <= exp_q[0].nr) begin
                    check_int("round_index", int'(round), exp_q[0].nr - k);
                end else if (k > exp_q[0].nr + 1) begin
                    check_int("ready_timeout", k, exp_q[0].nr + 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic start_op(input int sel, input logic [127:0] ct, input logic [127:0] pt,
                            input int nr, input bit hold);
        exp_t e;
        @(negedge clk);
        #1;
        cur_sel = sel;
        block   = ct;
        keylen  = (nr == 14);
        next    = 1'b1;
        @(posedge clk);
        #1;
        e.pt = pt;
        e.e0 = cyc;
        e.nr = nr;
        exp_q.push_back(e);
        if (!hold) next = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        check_int(nm, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_round(input int v);
        for (int n = 0; n < 30 && int'(round) != v; n++) begin
            @(negedge clk);
            #2;
        end
        check_int("wait_round", int'(round), v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        build_sbox();
        load_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        load_key(1, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);

        #1 rst_n = 1'b0;
        #20;
        check128("reset_new_block", new_block, '0);
        check_int("reset_round", int'(round), 0);
        check_int("reset_ready", int'(ready), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        start_op(0, B_CT, B_PT, 10, 1'b0);
        wait_done("fips_b_done");

        start_op(1, C1_CT, C_PT, 10, 1'b0);
        wait_done("c1_done");
        check_int("idle_round_zero", int'(round), 0);

        // next pulsed mid-run must be ignored
        start_op(1, C1_CT, C_PT, 10, 1'b0);
        wait_round(5);
        next = 1'b1;
        @(negedge clk);
        #1 next = 1'b0;
        wait_done("busy_done");

        // back-to-back: next stays high across the IDLE/ready cycle
        start_op(1, C1_CT, C_PT, 10, 1'b1);
        for (int n = 0; n < 20 && ready !== 1'b1; n++) begin
            @(negedge clk);
            #2;
        end
        check_int("b2b_first_ready", int'(ready), 1);
        cur_sel = 0;
        block   = B_CT;
        begin
            exp_t e;
            @(posedge clk);
            #1;
            e.pt = B_PT;
            e.e0 = cyc;
            e.nr = 10;
            exp_q.push_back(e);
            next = 1'b0;
        end
        wait_done("b2b_done");
        if (ready_cyc.size() >= 2)
            check_int("b2b_gap", ready_cyc[ready_cyc.size()-1] - ready_cyc[ready_cyc.size()-2], 12);
        else
            check_int("b2b_ready_count", ready_cyc.size(), 2);

        // reset mid-operation
        start_op(1, C1_CT, C_PT, 10, 1'b0);
        wait_round(6);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check128("midreset_new_block", new_block, '0);
        check_int("midreset_round", int'(round), 0);
        check_int("midreset_ready", int'(ready), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        start_op(1, C1_CT, C_PT, 10, 1'b0);
        wait_done("post_reset_done");

        load_key(0, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        start_op(0, C3_CT, C_PT, 14, 1'b0);
        wait_done("c3_done");
        check128("c3_hold", new_block, C_PT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
